// File: rtl/instr_mem_loader.sv
// Instruction-memory loader: encodes R/I/J instruction fields and writes one word per two cycles.
// Optional field legality checking is enabled by defining ENCODER_CHECK_EN.
module instr_mem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  fmt,
    input  logic [5:0]  op_code,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    input  logic        last,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  count
);

    // state | meaning
    // IDLE  | waiting for start
    // LOAD  | accepting instruction fields
    // WRITE | mem_we strobe for the registered word
    // DONE  | one-cycle end-of-session pulse
    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    localparam int RW = $clog2(DEPTH + 1);

    state_t        state, state_nxt;
    logic [31:0]   addr_nxt, wdata_nxt, enc_word;
    logic [7:0]    count_nxt;
    logic          err_nxt, last_q, last_nxt, illegal;
    logic [RW-1:0] left_q, left_nxt;

    always_comb begin
        case (fmt)
            2'd0:    enc_word = {op_code, rs, rt, rd, shamt, funct};
            2'd1:    enc_word = {op_code, rs, rt, imm};
            default: enc_word = {op_code, target};
        endcase
    end

`ifdef ENCODER_CHECK_EN
    always_comb begin
        illegal = (fmt == 2'd3)
               || (fmt == 2'd0 && op_code != 6'd0)
               || (fmt == 2'd2 && op_code != 6'd2 && op_code != 6'd3);
    end
`else
    always_comb begin
        illegal = (fmt == 2'd3);
    end
`endif

    // Separate down-counter for the DEPTH limit so it is independent of the 8-bit count wrap.
    always_comb begin
        state_nxt = state;
        addr_nxt  = mem_addr;
        wdata_nxt = mem_wdata;
        count_nxt = count;
        err_nxt   = err;
        last_nxt  = last_q;
        left_nxt  = left_q;
        in_ready  = 1'b0;
        mem_we    = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = LOAD;
                    addr_nxt  = BASE_ADDR;
                    count_nxt = 8'd0;
                    err_nxt   = 1'b0;
                    left_nxt  = RW'(DEPTH);
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (illegal) begin
                        err_nxt = 1'b1;
                        if (last) state_nxt = DONE;
                    end else begin
                        wdata_nxt = enc_word;
                        last_nxt  = last;
                        state_nxt = WRITE;
                    end
                end
            end
            WRITE: begin
                mem_we    = 1'b1;
                addr_nxt  = mem_addr + 32'd4;
                count_nxt = count + 8'd1;
                left_nxt  = left_q - RW'(1);
                if (last_q) begin
                    state_nxt = DONE;
                end else if (left_q == RW'(1)) begin
                    err_nxt   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    state_nxt = LOAD;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= 32'd0;
            count     <= 8'd0;
            err       <= 1'b0;
            last_q    <= 1'b0;
            left_q    <= '0;
        end else begin
            state     <= state_nxt;
            mem_addr  <= addr_nxt;
            mem_wdata <= wdata_nxt;
            count     <= count_nxt;
            err       <= err_nxt;
            last_q    <= last_nxt;
            left_q    <= left_nxt;
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: directed scenarios plus random sessions against a session-level model.
// Honours ENCODER_CHECK_EN in the reference legality rule.
module tb_instr_mem_loader;

    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, last = 1'b0;
    logic [1:0]  fmt = '0;
    logic [5:0]  op_code = '0, funct = '0;
    logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
    logic [15:0] imm = '0;
    logic [25:0] target = '0;
    logic        in_ready, mem_we, busy, done, err;
    logic [31:0] mem_addr, mem_wdata;
    logic [7:0]  count;

    int          n_checks = 0, n_errors = 0;
    logic [31:0] exp_addr;
    int          exp_count;
    logic        exp_err;
    bit          sess_done;

    instr_mem_loader #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .op_code(op_code), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .funct(funct), .imm(imm), .target(target), .last(last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err(err), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Field weights: op at 2^26, rs at 2^21, rt at 2^16, rd at 2^11, shamt at 2^6.
    function automatic logic [31:0] model_word(input logic [1:0] f, input logic [5:0] op,
            input logic [4:0] a, input logic [4:0] b, input logic [4:0] c, input logic [4:0] sh,
            input logic [5:0] fn, input logic [15:0] im, input logic [25:0] tg);
        logic [31:0] opw;
        opw = 32'(op) * 32'h0400_0000;
        if (f == 2'd0)
            return opw + 32'(a) * 32'h0020_0000 + 32'(b) * 32'h0001_0000
                 + 32'(c) * 32'h0000_0800 + 32'(sh) * 32'h0000_0040 + 32'(fn);
        else if (f == 2'd1)
            return opw + 32'(a) * 32'h0020_0000 + 32'(b) * 32'h0001_0000 + 32'(im);
        else
            return opw + 32'(tg);
    endfunction

    function automatic bit model_legal(input logic [1:0] f, input logic [5:0] op);
        if (f == 2'd3) return 1'b0;
`ifdef ENCODER_CHECK_EN
        if (f == 2'd0 && op != 6'd0) return 1'b0;
        if (f == 2'd2 && !(op == 6'd2 || op == 6'd3)) return 1'b0;
`endif
        return 1'b1;
    endfunction

    task automatic begin_session();
        chk("idle_ready", 32'(in_ready), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        exp_addr  = BASE;
        exp_count = 0;
        exp_err   = 1'b0;
        sess_done = 1'b0;
        chk("load_busy", 32'(busy), 32'd1);
        chk("load_ready", 32'(in_ready), 32'd1);
        chk("start_addr", mem_addr, exp_addr);
        chk("start_count", 32'(count), 32'd0);
        chk("start_err", 32'(err), 32'd0);
    endtask

    task automatic xfer(input logic [1:0] f, input logic [5:0] op, input logic [4:0] a,
            input logic [4:0] b, input logic [4:0] c, input logic [4:0] sh, input logic [5:0] fn,
            input logic [15:0] im, input logic [25:0] tg, input logic l);
        logic [31:0] w;
        chk("xfer_ready", 32'(in_ready), 32'd1);
        fmt = f; op_code = op; rs = a; rt = b; rd = c; shamt = sh; funct = fn;
        imm = im; target = tg; last = l; in_valid = 1'b1;
        start = 1'($urandom_range(0, 1));
        @(negedge clk);
        in_valid = 1'b0; last = 1'b0; start = 1'b0;
        if (model_legal(f, op)) begin
            w = model_word(f, op, a, b, c, sh, fn, im, tg);
            chk("write_we", 32'(mem_we), 32'd1);
            chk("write_addr", mem_addr, exp_addr);
            chk("write_wdata", mem_wdata, w);
            chk("write_ready", 32'(in_ready), 32'd0);
            chk("write_count", 32'(count), 32'(exp_count));
            exp_addr  = exp_addr + 32'd4;
            exp_count = exp_count + 1;
            @(negedge clk);
            chk("we_single", 32'(mem_we), 32'd0);
            if (l || exp_count == DEPTH) begin
                if (!l) exp_err = 1'b1;
                sess_done = 1'b1;
            end
        end else begin
            exp_err = 1'b1;
            chk("illegal_we", 32'(mem_we), 32'd0);
            sess_done = l;
        end
        chk("post_err", 32'(err), 32'(exp_err));
        chk("post_count", 32'(count), 32'(exp_count));
        chk("post_addr", mem_addr, exp_addr);
        chk("post_done", 32'(done), 32'(sess_done));
        chk("post_ready", 32'(in_ready), 32'(!sess_done));
    endtask

    task automatic end_session();
        @(negedge clk);
        chk("end_done", 32'(done), 32'd0);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_count", 32'(count), 32'(exp_count));
        chk("end_err", 32'(err), 32'(exp_err));
        chk("end_addr", mem_addr, exp_addr);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_addr"}, mem_addr, BASE);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        logic [1:0] rf;
        logic [5:0] rop;
        logic       rl;
        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // R-format add, single word
        begin_session();
        xfer(2'd0, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 1'b1);
        chk("add_word_model", model_word(2'd0, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0), 32'h0022_1820);
        end_session();

        // three-word session: lw, R, j
        begin_session();
        xfer(2'd1, 6'h23, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'd4, 26'h0, 1'b0);
        xfer(2'd0, 6'd0, 5'd4, 5'd5, 5'd6, 5'd2, 6'h22, 16'h0, 26'h0, 1'b0);
        xfer(2'd2, 6'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h10, 1'b1);
        chk("j_word", mem_wdata, 32'h0800_0010);
        end_session();

        // overflow at DEPTH without last
        begin_session();
        for (int k = 0; k < DEPTH; k++)
            xfer(2'd1, 6'h08, 5'(k), 5'd9, 5'd0, 5'd0, 6'd0, 16'(k * 3 + 1), 26'h0, 1'b0);
        chk("ovf_err", 32'(err), 32'd1);
        end_session();
        in_valid = 1'b1; fmt = 2'd1;
        chk("ovf_fifth_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("ovf_fifth_we", 32'(mem_we), 32'd0);
        chk("ovf_fifth_count", 32'(count), 32'(DEPTH));
        in_valid = 1'b0;

        // illegal fmt mid-session, then R with op 8
        begin_session();
        xfer(2'd1, 6'h0d, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hbeef, 26'h0, 1'b0);
        xfer(2'd3, 6'h3f, 5'd7, 5'd7, 5'd7, 5'd7, 6'h3f, 16'hffff, 26'h3ff_ffff, 1'b0);
        xfer(2'd0, 6'd0, 5'd9, 5'd10, 5'd11, 5'd0, 6'h21, 16'h0, 26'h0, 1'b0);
        xfer(2'd0, 6'h08, 5'd31, 5'd0, 5'd0, 5'd0, 6'h08, 16'h0, 26'h0, 1'b1);
        end_session();

        // random sessions
        for (int s = 0; s < 8; s++) begin
            begin_session();
            for (int k = 0; k < 12 && !sess_done; k++) begin
                rf  = 2'($urandom_range(0, 3));
                rop = ($urandom_range(0, 2) == 0) ? 6'($urandom) :
                      (rf == 2'd2) ? 6'($urandom_range(2, 3)) :
                      (rf == 2'd0) ? 6'd0 : 6'($urandom);
                rl  = (k == 11) || ($urandom_range(0, 3) == 0);
                xfer(rf, rop, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                     6'($urandom), 16'($urandom), 26'($urandom), rl);
            end
            end_session();
        end

        // reset asserted during WRITE
        begin_session();
        fmt = 2'd1; op_code = 6'h2b; rs = 5'd3; rt = 5'd4; imm = 16'h1234; last = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rstw_we_before", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("rstw");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("rstw_rel");
        begin_session();
        xfer(2'd2, 6'd3, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h123_4567, 1'b1);
        end_session();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
